// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
`timescale 1ns/1ps
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd4;

  // Bits needed to hold the values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_convert_seq_digit_adj.sv
// One BCD digit adjustment step: a digit above four gets +3 before the shift.
`timescale 1ns/1ps
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add-3 correction, no carry into the neighbouring digit.
  always_comb begin
    if (digit_in > BCD_ADJ_THRESH) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
`timescale 1ns/1ps
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  ovf_out
);

  localparam int CNT_W = clog2(BIN_W + 1);
  localparam int ACC_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(1);

  bcd_state_e       state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_adj_s;
  logic [ACC_W-1:0] bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj_s[4*g +: 4])
    );
  end

  // Next-state, datapath and result capture.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (SIGNED && bin_in[BIN_W-1]) begin
            shift_d = (~bin_in) + BIN_ONE;
            sign_d  = 1'b1;
          end else begin
            shift_d = bin_in;
            sign_d  = 1'b0;
          end
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d   = {acc_adj_s[ACC_W-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_ONE;
        // A set top bit after adjustment is about to fall off the accumulator.
        if (acc_adj_s[ACC_W-1]) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (cnt_q == CNT_ONE) begin
          bcd_d   = {acc_adj_s[ACC_W-2:0], shift_q[BIN_W-1]};
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;
  assign ovf_out   = ovf_q;

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), processing one input bit per clock.
- Generalises the combinational 10-bit/3-digit converter: configurable input width and digit count, optional two's-complement input, overflow detection, valid/ready handshakes on both sides.
- Sits between the ALU result register and the seven-segment display driver.

Parameters:
- BIN_W, 10, binary input width in bits (>=2).
- DIGITS, 4, number of BCD output digits (>=1).
- SIGNED, 0, 1 = input is two's complement; output is magnitude plus sign flag.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block accepts a new input.
- bin_in  input  BIN_W  binary operand.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- sign_out  output  1  1 = negative input (always 0 when SIGNED=0).
- ovf_out  output  1  value exceeds 10^DIGITS-1; bcd_out holds the low DIGITS digits of the truncated result.

Behaviour:
- All state updates on the rising edge of clk. reset is synchronous, active-high, and overrides everything, including a conversion in progress.
- Reset values:
  - FSM in IDLE.
  - in_ready = 1, out_valid = 0.
  - bcd_out = 0, sign_out = 0, ovf_out = 0.
  - Bit counter = 0; shift register = 0.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid && in_ready:
    - Latch the operand magnitude into the shift register. If SIGNED=1 and bin_in[BIN_W-1]=1, latch the two's-complement negation and set sign_out = 1; otherwise set sign_out = 0.
    - Clear the BCD accumulator and ovf_out; load the bit counter with BIN_W.
    - Go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle performs one step:
    - Every digit > 4 gets +3.
    - The accumulator shifts left by one, taking in the shift-register MSB.
    - The shift register shifts left by one.
    - The counter decrements.
    - If the top digit's bit 3 is 1 after the add-3 (that bit would be shifted out), ovf_out latches 1 (sticky for this conversion).
    - When the counter reaches 1 on the current step, go to DONE.
  - DONE: out_valid = 1; bcd_out, sign_out and ovf_out are stable. On out_ready, go to IDLE. No new input is accepted in DONE.
- Latency: acceptance at edge k → out_valid = 1 after edge k+BIN_W. Minimum spacing between acceptances is BIN_W+2 cycles (with out_ready held high).
- bcd_out updates only on the transition into DONE. Intermediate accumulator values are never visible on bcd_out. bcd_out holds its value in IDLE until the next result.
- Most-negative signed input (-2^(BIN_W-1)): its magnitude 2^(BIN_W-1) fits in BIN_W unsigned bits, so it needs no special case.
- Zero input: bcd_out = 0, sign_out = 0, even when SIGNED=1.
- out_ready asserted outside DONE: ignored.
- in_valid outside IDLE: ignored. The upstream must hold its data until in_ready.
- Reset asserted in SHIFT or DONE: the result is discarded and all outputs take their reset values on the next edge.
- Widths: the accumulator is 4*DIGITS bits. Each per-digit add-3 is 4 bits wide with no carry between digits. Overflow is detected only through the top digit.

Decomposition:
- Package bcd_pkg:
  - FSM state encoding constants (IDLE, SHIFT, DONE).
  - clog2 function used to size the bit counter (clog2(BIN_W+1)).
  - Constant BCD_ADJ_THRESH = 4.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out; adds 3 when the input > 4. Instantiated DIGITS times with a generate loop.

Test Plan:
- Default params, bin_in = 1023 → out_valid rises 10 cycles after acceptance; bcd_out = 0x1023, ovf_out = 0, sign_out = 0.
- Default params, bin_in = 0, then bin_in = 9 back-to-back (out_ready held 1) → 0x0000 then 0x0009; second acceptance exactly 12 cycles after the first.
- BIN_W=10, DIGITS=2, bin_in = 255 → ovf_out = 1; bcd_out = 0x55 (low two digits of the truncated result). bin_in = 99 → 0x99, ovf_out = 0.
- SIGNED=1, BIN_W=10: bin_in = 10'h200 (-512) → sign_out = 1, bcd_out = 0x0512; bin_in = 10'h3FF (-1) → sign_out = 1, 0x0001.
- Backpressure: out_ready = 0 for 20 cycles after out_valid → out_valid and bcd_out stay constant and in_ready stays 0; the result clears one cycle after out_ready = 1.
- Assert reset for one cycle midway through SHIFT → next cycle: IDLE, in_ready = 1, out_valid = 0, bcd_out = 0. A fresh conversion of 500 then yields 0x0500.
